// File: rtl/instr_encoder.sv
// RV32I instruction encoder: packs decoded fields into a 32-bit word, two-stage pipeline.
// Optional ENCODER_STATS_EN adds saturating enc_count/err_count output-handshake counters.
module instr_encoder #(
  parameter logic [31:0] NOP_WORD = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [4:0]  rd_addr,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  input  logic [31:0] imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_err,
  output logic [1:0]  out_err_code
`ifdef ENCODER_STATS_EN
  ,
  output logic [15:0] enc_count,
  output logic [15:0] err_count
`endif
);

  localparam logic [2:0] FmtR = 3'd0;
  localparam logic [2:0] FmtI = 3'd1;
  localparam logic [2:0] FmtS = 3'd2;
  localparam logic [2:0] FmtB = 3'd3;
  localparam logic [2:0] FmtU = 3'd4;
  localparam logic [2:0] FmtJ = 3'd5;

  localparam logic [1:0] ErrNone  = 2'd0;
  localparam logic [1:0] ErrRange = 2'd1;
  localparam logic [1:0] ErrAlign = 2'd2;
  localparam logic [1:0] ErrFmt   = 2'd3;

  logic        s1_valid_q;
  logic [2:0]  s1_fmt_q;
  logic [6:0]  s1_opcode_q;
  logic [2:0]  s1_funct3_q;
  logic [6:0]  s1_funct7_q;
  logic [4:0]  s1_rd_q;
  logic [4:0]  s1_rs1_q;
  logic [4:0]  s1_rs2_q;
  logic [31:0] s1_imm_q;

  logic        s1_adv;
  logic        in_hs;
  logic        out_hs;
  logic [31:0] enc_word;
  logic [1:0]  err_code;
  logic        imm_fits12;
  logic        imm_fits13;
  logic        imm_fits21;

  // S1 may hand over whenever S2 is empty or draining this cycle.
  assign s1_adv   = !out_valid || out_ready;
  assign in_ready = !s1_valid_q || s1_adv;
  assign in_hs    = in_valid && in_ready;
  assign out_hs   = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_fmt_q    <= '0;
      s1_opcode_q <= '0;
      s1_funct3_q <= '0;
      s1_funct7_q <= '0;
      s1_rd_q     <= '0;
      s1_rs1_q    <= '0;
      s1_rs2_q    <= '0;
      s1_imm_q    <= '0;
    end else begin
      if (in_hs) begin
        s1_valid_q  <= 1'b1;
        s1_fmt_q    <= fmt;
        s1_opcode_q <= opcode;
        s1_funct3_q <= funct3;
        s1_funct7_q <= funct7;
        s1_rd_q     <= rd_addr;
        s1_rs1_q    <= rs1_addr;
        s1_rs2_q    <= rs2_addr;
        s1_imm_q    <= imm;
      end else if (s1_adv) begin
        s1_valid_q <= 1'b0;
      end
    end
  end

  // Sign-extension checks: upper bits must all be copies of the sign bit.
  assign imm_fits12 = (&s1_imm_q[31:11]) || !(|s1_imm_q[31:11]);
  assign imm_fits13 = (&s1_imm_q[31:12]) || !(|s1_imm_q[31:12]);
  assign imm_fits21 = (&s1_imm_q[31:20]) || !(|s1_imm_q[31:20]);

  always_comb begin
    enc_word = '0;
    err_code = ErrNone;
    case (s1_fmt_q)
      FmtR: begin
        enc_word = {s1_funct7_q, s1_rs2_q, s1_rs1_q, s1_funct3_q, s1_rd_q, s1_opcode_q};
      end
      FmtI: begin
        enc_word = {s1_imm_q[11:0], s1_rs1_q, s1_funct3_q, s1_rd_q, s1_opcode_q};
        if (!imm_fits12) err_code = ErrRange;
      end
      FmtS: begin
        enc_word = {s1_imm_q[11:5], s1_rs2_q, s1_rs1_q, s1_funct3_q, s1_imm_q[4:0],
                    s1_opcode_q};
        if (!imm_fits12) err_code = ErrRange;
      end
      FmtB: begin
        enc_word = {s1_imm_q[12], s1_imm_q[10:5], s1_rs2_q, s1_rs1_q, s1_funct3_q,
                    s1_imm_q[4:1], s1_imm_q[11], s1_opcode_q};
        if (s1_imm_q[0])      err_code = ErrAlign;
        else if (!imm_fits13) err_code = ErrRange;
      end
      FmtU: begin
        enc_word = {s1_imm_q[31:12], s1_rd_q, s1_opcode_q};
        if (|s1_imm_q[11:0]) err_code = ErrAlign;
      end
      FmtJ: begin
        enc_word = {s1_imm_q[20], s1_imm_q[10:1], s1_imm_q[11], s1_imm_q[19:12], s1_rd_q,
                    s1_opcode_q};
        if (s1_imm_q[0])      err_code = ErrAlign;
        else if (!imm_fits21) err_code = ErrRange;
      end
      default: begin
        enc_word = '0;
      end
    endcase
    // Bad format or non-32-bit opcode outranks every immediate check.
    if (s1_fmt_q > FmtJ || s1_opcode_q[1:0] != 2'b11) err_code = ErrFmt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      out_instr    <= '0;
      out_err      <= 1'b0;
      out_err_code <= '0;
    end else if (s1_adv) begin
      out_valid <= s1_valid_q;
      if (s1_valid_q) begin
        out_instr    <= (err_code != ErrNone) ? NOP_WORD : enc_word;
        out_err      <= (err_code != ErrNone);
        out_err_code <= err_code;
      end
    end
  end

`ifdef ENCODER_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enc_count <= '0;
      err_count <= '0;
    end else if (out_hs) begin
      if (enc_count != 16'hFFFF) enc_count <= enc_count + 16'd1;
      if (out_err && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
    end
  end
`else
  logic unused_out_hs;
  assign unused_out_hs = out_hs;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: fixed vectors, backpressure, async reset, and a randomized
// round-trip stream checked by decoding the emitted word back into fields.
module tb_instr_encoder;

  typedef struct {
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } vec_t;

  typedef struct {
    vec_t        v;
    logic [1:0]  code;
    logic        has_word;
    logic [31:0] word;
  } exp_t;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  fmt = '0;
  logic [6:0]  opcode = '0;
  logic [2:0]  funct3 = '0;
  logic [6:0]  funct7 = '0;
  logic [4:0]  rd_addr = '0;
  logic [4:0]  rs1_addr = '0;
  logic [4:0]  rs2_addr = '0;
  logic [31:0] imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic        out_err;
  logic [1:0]  out_err_code;
`ifdef ENCODER_STATS_EN
  logic [15:0] enc_count;
  logic [15:0] err_count;
`endif

  int n_vec = 0;
  int n_bad = 0;
  int exp_enc = 0;
  int exp_err = 0;
  exp_t stim_q[$];
  exp_t sb_q[$];

  always #5 clk = ~clk;

  instr_encoder dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .fmt          (fmt),
    .opcode       (opcode),
    .funct3       (funct3),
    .funct7       (funct7),
    .rd_addr      (rd_addr),
    .rs1_addr     (rs1_addr),
    .rs2_addr     (rs2_addr),
    .imm          (imm),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_instr    (out_instr),
    .out_err      (out_err),
    .out_err_code (out_err_code)
`ifdef ENCODER_STATS_EN
    ,
    .enc_count    (enc_count),
    .err_count    (err_count)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3,
                              input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] r1,
                              input logic [4:0] r2, input logic [31:0] im);
    vec_t v;
    v.fmt = f; v.opcode = op; v.funct3 = f3; v.funct7 = f7;
    v.rd = rd; v.rs1 = r1; v.rs2 = r2; v.imm = im;
    return v;
  endfunction

  // Error classification from the value ranges each format can represent.
  function automatic logic [1:0] model_code(input vec_t v);
    longint s;
    s = longint'($signed(v.imm));
    if (v.fmt >= 3'd6 || v.opcode[1:0] != 2'b11) return 2'd3;
    case (v.fmt)
      3'd1, 3'd2: if (s < -2048 || s > 2047) return 2'd1;
      3'd3: begin
        if (s % 2 != 0) return 2'd2;
        if (s < -4096 || s > 4095) return 2'd1;
      end
      3'd4: if (v.imm % 4096 != 0) return 2'd2;
      3'd5: begin
        if (s % 2 != 0) return 2'd2;
        if (s < -1048576 || s > 1048575) return 2'd1;
      end
      default: ;
    endcase
    return 2'd0;
  endfunction

  // Decoder view of a word: do the fields it carries reproduce the inputs?
  function automatic bit round_trip(input vec_t v, input logic [31:0] w);
    logic [31:0] di;
    if (w[6:0] != v.opcode) return 0;
    case (v.fmt)
      3'd0: return w[11:7] == v.rd && w[14:12] == v.funct3 && w[19:15] == v.rs1 &&
                   w[24:20] == v.rs2 && w[31:25] == v.funct7;
      3'd1: begin
        di = {{20{w[31]}}, w[31:20]};
        return w[11:7] == v.rd && w[14:12] == v.funct3 && w[19:15] == v.rs1 && di == v.imm;
      end
      3'd2: begin
        di = {{20{w[31]}}, w[31:25], w[11:7]};
        return w[14:12] == v.funct3 && w[19:15] == v.rs1 && w[24:20] == v.rs2 && di == v.imm;
      end
      3'd3: begin
        di = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
        return w[14:12] == v.funct3 && w[19:15] == v.rs1 && w[24:20] == v.rs2 && di == v.imm;
      end
      3'd4: return w[11:7] == v.rd && {w[31:12], 12'h000} == v.imm;
      3'd5: begin
        di = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
        return w[11:7] == v.rd && di == v.imm;
      end
      default: return 0;
    endcase
  endfunction

  function automatic vec_t gen_rand();
    vec_t v;
    v.fmt = 3'($urandom_range(0, 5));
    if ($urandom_range(0, 19) == 0) v.fmt = 3'($urandom_range(6, 7));
    case (v.fmt)
      3'd0: v.opcode = 7'h33;
      3'd1: v.opcode = ($urandom_range(0, 1) == 0) ? 7'h13 : 7'h03;
      3'd2: v.opcode = 7'h23;
      3'd3: v.opcode = 7'h63;
      3'd4: v.opcode = ($urandom_range(0, 1) == 0) ? 7'h37 : 7'h17;
      default: v.opcode = 7'h6f;
    endcase
    if ($urandom_range(0, 19) == 0) v.opcode = 7'($urandom);
    v.funct3 = 3'($urandom); v.funct7 = 7'($urandom);
    v.rd = 5'($urandom); v.rs1 = 5'($urandom); v.rs2 = 5'($urandom);
    case (v.fmt)
      3'd3: v.imm = 32'((int'($urandom_range(0, 4095)) - 2048) * 2);
      3'd4: v.imm = $urandom & 32'hFFFFF000;
      3'd5: v.imm = 32'((int'($urandom_range(0, 1048575)) - 524288) * 2);
      default: v.imm = 32'(int'($urandom_range(0, 4095)) - 2048);
    endcase
    if ($urandom_range(0, 9) == 0) v.imm = $urandom;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    fmt = v.fmt; opcode = v.opcode; funct3 = v.funct3; funct7 = v.funct7;
    rd_addr = v.rd; rs1_addr = v.rs1; rs2_addr = v.rs2; imm = v.imm;
  endtask

  task automatic check_out(input exp_t e);
    chk("err", 32'(out_err), 32'(e.code != 2'd0));
    chk("err_code", 32'(out_err_code), 32'(e.code));
    if (e.code != 2'd0) chk("nop_word", out_instr, NOP);
    else if (e.has_word) chk("instr", out_instr, e.word);
    if (e.code == 2'd0) chk("round_trip", 32'(round_trip(e.v, out_instr)), 32'd1);
    exp_enc++;
    if (e.code != 2'd0) exp_err++;
  endtask

  // Streams stim_q through the DUT; out_ready low for hold_low cycles, then rdy_pct% high.
  task automatic run_stream(input int rdy_pct, input int hold_low, output int acc_at_block);
    int cyc, acc;
    bit stall;
    logic [31:0] p_instr;
    logic [1:0] p_code;
    logic p_err;
    cyc = 0; acc = 0; stall = 0; acc_at_block = -1;
    p_instr = '0; p_code = '0; p_err = 1'b0;
    while (stim_q.size() > 0 || sb_q.size() > 0) begin
      if (cyc > 20000) begin
        chk("stream_timeout", 32'(sb_q.size() + stim_q.size()), 32'd0);
        sb_q.delete(); stim_q.delete();
        break;
      end
      @(negedge clk);
      in_valid = (stim_q.size() > 0);
      if (in_valid) drive(stim_q[0].v);
      out_ready = (cyc >= hold_low) && ($urandom_range(1, 100) <= rdy_pct);
      #1;
      if (stall) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_instr", out_instr, p_instr);
        chk("stall_code", {29'd0, p_err, p_code}, {29'd0, out_err, out_err_code});
      end
      if (in_valid && !in_ready && acc_at_block < 0) acc_at_block = acc;
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) chk("unexpected_word", out_instr, 32'hxxxxxxxx);
        else check_out(sb_q.pop_front());
      end
      if (in_valid && in_ready) begin
        sb_q.push_back(stim_q.pop_front());
        acc++;
      end
      stall = out_valid && !out_ready;
      p_instr = out_instr; p_err = out_err; p_code = out_err_code;
      cyc++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic push_vec(input vec_t v, input logic [1:0] code, input bit has_w,
                          input logic [31:0] w);
    exp_t e;
    e.v = v; e.code = code; e.has_word = has_w; e.word = w;
    stim_q.push_back(e);
  endtask

  typedef struct {
    vec_t        v;
    logic [31:0] word;
    logic [1:0]  code;
  } tv_t;

  tv_t tbl[$];
  int blk;

  initial begin
    tbl.push_back('{mk(1, 7'h13, 0, 0, 1, 2, 0, 32'hFFFFFFFF), 32'hFFF10093, 2'd0});
    tbl.push_back('{mk(2, 7'h23, 2, 0, 0, 2, 5, 32'h8), 32'h00512423, 2'd0});
    tbl.push_back('{mk(4, 7'h37, 0, 0, 5, 0, 0, 32'h12345000), 32'h123452B7, 2'd0});
    tbl.push_back('{mk(3, 7'h63, 0, 0, 0, 1, 2, 32'h3), NOP, 2'd2});
    tbl.push_back('{mk(5, 7'h6f, 0, 0, 1, 0, 0, 32'h00100000), NOP, 2'd1});
    tbl.push_back('{mk(7, 7'h13, 0, 0, 1, 2, 3, 32'h3), NOP, 2'd3});
    tbl.push_back('{mk(0, 7'h33, 0, 7'h00, 3, 1, 2, 32'h0), 32'h002081B3, 2'd0});
    tbl.push_back('{mk(0, 7'h33, 0, 7'h20, 3, 1, 2, 32'hDEADBEEF), 32'h402081B3, 2'd0});
    tbl.push_back('{mk(3, 7'h63, 0, 0, 0, 1, 2, 32'hFFFFFFFC), 32'hFE208EE3, 2'd0});
    tbl.push_back('{mk(5, 7'h6f, 0, 0, 1, 0, 0, 32'h8), 32'h008000EF, 2'd0});
    tbl.push_back('{mk(1, 7'h13, 0, 0, 0, 0, 0, 32'hFFFFF800), 32'h80000013, 2'd0});
    tbl.push_back('{mk(1, 7'h13, 0, 0, 0, 0, 0, 32'h00000800), NOP, 2'd1});
    tbl.push_back('{mk(4, 7'h37, 0, 0, 5, 0, 0, 32'h12345001), NOP, 2'd2});
    tbl.push_back('{mk(0, 7'h10, 0, 0, 1, 1, 1, 32'h0), NOP, 2'd3});
    tbl.push_back('{mk(3, 7'h63, 0, 0, 0, 1, 2, 32'h00001000), NOP, 2'd1});

    // Reset state
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_err", {29'd0, out_err, out_err_code}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Latency: handshake edge, then out_valid after the following edge
    @(negedge clk);
    drive(tbl[0].v); in_valid = 1'b1; out_ready = 1'b1;
    #1 chk("lat_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    #1 chk("lat_valid_early", 32'(out_valid), 32'd0);
    @(negedge clk);
    #1 chk("lat_valid", 32'(out_valid), 32'd1);
    chk("lat_instr", out_instr, 32'hFFF10093);
    exp_enc++;
    @(negedge clk);
    #1 chk("lat_drained", 32'(out_valid), 32'd0);

    foreach (tbl[i]) push_vec(tbl[i].v, tbl[i].code, 1'b1, tbl[i].word);
    run_stream(100, 0, blk);

    // Backpressure: 4 back-to-back words, out_ready low for the first 5 cycles
    for (int i = 0; i < 4; i++) push_vec(tbl[6 + i].v, tbl[6 + i].code, 1'b1, tbl[6 + i].word);
    run_stream(100, 5, blk);
    chk("accepted_before_block", 32'(blk), 32'd2);

    // Async reset with two words in flight
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; drive(tbl[1].v);
    @(negedge clk);
    drive(tbl[2].v);
    @(negedge clk);
    in_valid = 1'b0;
    #1 chk("inflight_valid", 32'(out_valid), 32'd1);
    #1 rst_n = 1'b0;
    #1 chk("async_out_valid", 32'(out_valid), 32'd0);
    chk("async_out_instr", out_instr, 32'd0);
    chk("async_in_ready", 32'(in_ready), 32'd1);
    exp_enc = 0; exp_err = 0;
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    chk("post_rst_empty", 32'(out_valid), 32'd0);
    push_vec(tbl[1].v, tbl[1].code, 1'b1, tbl[1].word);
    run_stream(100, 0, blk);

    // Randomized round trip with random backpressure
    for (int i = 0; i < 600; i++) begin
      vec_t v;
      v = gen_rand();
      push_vec(v, model_code(v), 1'b0, 32'd0);
    end
    run_stream(70, 0, blk);

`ifdef ENCODER_STATS_EN
    chk("enc_count", 32'(enc_count), 32'(exp_enc));
    chk("err_count", 32'(err_count), 32'(exp_err));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
